// File: rtl/gpio_bcd_periph_if.sv
// gpio_bcd_periph_if: register bus between the core and the GPIO peripheral.
//   addr    - register select (0 LED, 1 SW, 2 DISP, 3 STATUS)
//   memw    - write strobe
//   read_en - read strobe
//   dataw   - write data
//   datar   - read data, combinational from the peripheral
interface gpio_bcd_periph_if #(
    parameter int unsigned DW = 16
) ();
    logic [1:0]    addr;
    logic          memw;
    logic          read_en;
    logic [DW-1:0] dataw;
    logic [DW-1:0] datar;

    modport master (output addr, memw, read_en, dataw, input datar);
    modport slave  (input addr, memw, read_en, dataw, output datar);
endinterface

// File: rtl/gpio_bcd_periph.sv
// gpio_bcd_periph: memory-mapped GPIO with LED register, debounced switches
// and an NDIG-digit 7-segment display fed by a sequential double-dabble
// binary-to-BCD converter.
//   clk, reset - clock, synchronous active-high reset
//   bus        - register bus (slave side), see gpio_bcd_periph_if
//   SW         - raw asynchronous switches
//   LEDR       - LED register
//   HEX        - digit i at [7i+6:7i], active-low segments, digit 0 = units
//   irq        - level interrupt PEND & IE (only when GPIO_IRQ_EN is defined)
// Optional feature macro: GPIO_IRQ_EN (switch-change interrupt, PEND/IE bits).
module gpio_bcd_periph #(
    parameter int unsigned DW         = 16,
    parameter int unsigned NDIG       = 4,
    parameter int unsigned DEB_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    gpio_bcd_periph_if.slave     bus,
    input  logic [DW-1:0]        SW,
    output logic [DW-1:0]        LEDR,
    output logic [NDIG*7-1:0]    HEX,
    output logic                 irq
);
    // Decimal digits needed for 2^DW-1: floor(DW*log10(2)) + 1.
    localparam int unsigned NDEC = (DW * 30103) / 100000 + 1;
    localparam int unsigned NBCD = (NDEC > NDIG) ? NDEC : NDIG;
    localparam int unsigned BW   = NBCD * 4;
    localparam int unsigned CW   = $clog2(DEB_CYCLES);
    localparam int unsigned STW  = $clog2(DW + 1);
    localparam logic [6:0]  SEG_DASH = 7'b0111111;
    localparam logic [6:0]  SEG_ZERO = 7'b1000000;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    logic [DW-1:0]  sync1_q, sync2_q, sw_deb_q, disp_q, val_q;
    logic [CW-1:0]  deb_cnt_q;
    logic [BW-1:0]  bcd_q, bcd_adj_c;
    logic [STW-1:0] step_q;
    logic           ovf_q, ovf_c, deb_upd_c, busy_c;
    logic           ie_q, pend_q;
    logic [NDIG*7-1:0] hex_c;
    state_t         state_q, state_d;

    logic wr_led, wr_disp;
    assign wr_led  = bus.memw && (bus.addr == 2'd0);
    assign wr_disp = bus.memw && (bus.addr == 2'd2);

    // LED register.
    always_ff @(posedge clk) begin
        if (reset) LEDR <= '0;
        else if (wr_led) LEDR <= bus.dataw;
    end

    // Switch synchroniser and debouncer; sync1 is the incoming sample of the
    // synchronised vector sync2, so a mismatch means the vector is moving.
    assign deb_upd_c = (deb_cnt_q == CW'(DEB_CYCLES - 1)) && (sync2_q != sw_deb_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_cnt_q <= '0;
            sw_deb_q  <= '0;
        end else begin
            sync1_q <= SW;
            sync2_q <= sync1_q;
            if (sync1_q != sync2_q)                   deb_cnt_q <= '0;
            else if (deb_cnt_q != CW'(DEB_CYCLES - 1)) deb_cnt_q <= deb_cnt_q + CW'(1);
            if (deb_upd_c) sw_deb_q <= sync2_q;
        end
    end

    // Conversion FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Conversion FSM next state; a DISP write always (re)starts.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = S_IDLE;
            S_SHIFT: if (step_q == STW'(DW - 1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (wr_disp) state_d = S_SHIFT;
    end

    assign busy_c = (state_q != S_IDLE);

    // Double-dabble add-3 correction, overflow detect and segment decode.
    always_comb begin
        bcd_adj_c = bcd_q;
        for (int i = 0; i < int'(NBCD); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        ovf_c = 1'b0;
        for (int i = int'(NDIG); i < int'(NBCD); i++) begin
            ovf_c = ovf_c | (|bcd_q[4*i +: 4]);
        end
        hex_c = '0;
        for (int i = 0; i < int'(NDIG); i++) begin
            hex_c[7*i +: 7] = ovf_c ? SEG_DASH : seg7(bcd_q[4*i +: 4]);
        end
    end

    // Conversion datapath; HEX/OVF only update in DONE so partial results never show.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_q <= '0;
            val_q  <= '0;
            bcd_q  <= '0;
            step_q <= '0;
            ovf_q  <= 1'b0;
            HEX    <= {NDIG{SEG_ZERO}};
        end else if (wr_disp) begin
            disp_q <= bus.dataw;
            val_q  <= bus.dataw;
            bcd_q  <= '0;
            step_q <= '0;
        end else begin
            unique case (state_q)
                S_SHIFT: begin
                    bcd_q  <= {bcd_adj_c[BW-2:0], val_q[DW-1]};
                    val_q  <= {val_q[DW-2:0], 1'b0};
                    step_q <= step_q + STW'(1);
                end
                S_DONE: begin
                    HEX   <= hex_c;
                    ovf_q <= ovf_c;
                end
                default: ;
            endcase
        end
    end

`ifdef GPIO_IRQ_EN
    logic wr_stat;
    assign wr_stat = bus.memw && (bus.addr == 2'd3);

    // Pending/enable bits; a new change wins over a same-cycle W1C clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ie_q   <= 1'b0;
            pend_q <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (wr_stat) ie_q <= bus.dataw[3];
            pend_q <= deb_upd_c | (pend_q & ~(wr_stat & bus.dataw[2]));
            irq    <= pend_q & ie_q;
        end
    end
`else
    assign ie_q   = 1'b0;
    assign pend_q = 1'b0;
    assign irq    = 1'b0;
`endif

    // Read mux; returns pre-edge register values.
    always_comb begin
        bus.datar = '0;
        if (bus.read_en) begin
            unique case (bus.addr)
                2'd0:    bus.datar = LEDR;
                2'd1:    bus.datar = sw_deb_q;
                2'd2:    bus.datar = disp_q;
                default: bus.datar = DW'({ie_q, pend_q, ovf_q, busy_c});
            endcase
        end
    end
endmodule

// File: doc/gpio_bcd_periph.md
Name: gpio_bcd_periph

Overview:
- Parametrised memory-mapped GPIO peripheral: LED output register, debounced switch input, and NDIG-digit decimal 7-segment display.
- The display value is converted binary→BCD by a sequential double-dabble engine.
- An optional switch-change interrupt is provided.
- Sits on the core's data bus next to data memory; the core reaches it through a 2-bit register address.

Parameters:
- DW, 16, data/bus width; also LEDR and SW width.
- NDIG, 4, number of 7-segment digits driven (1..8).
- DEB_CYCLES, 50000, cycles the synchronised SW vector must stay unchanged before it is accepted (≥2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- addr  in  2  register select: 0 LED, 1 SW, 2 DISP, 3 STATUS
- memw  in  1  write strobe
- read_en  in  1  read strobe
- dataw  in  DW  write data
- datar  out  DW  read data (combinational)
- SW  in  DW  raw asynchronous switches
- LEDR  out  DW  LED register
- HEX  out  NDIG*7  digit i at bits [7i+6:7i]; active-low segments; digit 0 = units
- irq  out  1  level interrupt (only with GPIO_IRQ_EN)

Behaviour:
- One clock; reset is synchronous and active-high. Reset applies on a clk edge while reset=1 and overrides all writes and the FSM.
- Reset values:
  - LEDR=0, DISP=0, debounced SW=0, sync flops=0, debounce counter=0.
  - STATUS=0, FSM=IDLE, irq=0.
  - HEX = NDIG copies of "0" (7'b1000000).
- Writes (memw=1) take effect on the edge:
  - addr0: LEDR←dataw.
  - addr1: ignored.
  - addr2: DISP←dataw and a conversion starts.
  - addr3: bit3 (IE)←dataw[3]; bit2 pending cleared if dataw[2]=1 (W1C). Other bits read-only.
- Reads: datar = read_en ? reg[addr] : 0. Values are pre-edge, so a read and write in the same cycle return the old value.
  - addr0: LEDR.
  - addr1: debounced SW.
  - addr2: DISP.
  - addr3: {0…, IE, PEND, OVF, BUSY} in bits [3:0].
- SW path:
  - 2-FF synchroniser.
  - Counter resets to 0 whenever the synchronised vector differs from the previous sample; otherwise it increments, saturating.
  - When the counter reaches DEB_CYCLES-1 and the synchronised vector ≠ debounced value: debounced value updates (whole vector), and PEND sets.
  - Total latency from a stable SW change to the SW register update = 2 + DEB_CYCLES cycles.
- Conversion FSM IDLE→SHIFT→DONE→IDLE:
  - DISP write: latch value, clear BCD accumulator, enter SHIFT.
  - SHIFT runs exactly DW cycles: add-3 to every BCD nibble ≥5, then shift left one bit from the value.
  - DONE (1 cycle): register HEX from the low NDIG nibbles, then return to IDLE.
  - BUSY=1 in SHIFT and DONE. HEX changes only on the DONE edge, never showing partial values.
  - Write edge at cycle 0 → HEX valid and BUSY=0 after edge DW+1 (edge 17 for DW=16).
- Accumulator holds enough nibbles for 2^DW-1 (5 for DW=16).
- Overflow: if the value > 10^NDIG-1, all digits show "-" (7'b0111111) and OVF=1; otherwise OVF=0. OVF updates at DONE.
- A DISP write while BUSY aborts and restarts with the new value. Only the last value is ever displayed.
- BCD digits 0-9 use the standard active-low patterns (e.g. 1=7'b1111001, 8=7'b0000000).
- PEND set and W1C in the same cycle: set wins.
- Reset mid-conversion: FSM→IDLE and HEX→zeros immediately.

Optional Feature:
- GPIO_IRQ_EN defined:
  - irq = PEND & IE, registered (asserts the cycle after PEND&IE becomes true).
  - PEND/IE readable and writable as above.
- Undefined:
  - irq tied 0; STATUS bits 3:2 read 0; writes to them ignored; no PEND logic synthesised.

Test Plan:
- Reset then read all regs (read_en=1, addr 0..3) → datar=0 each; HEX = four "0" patterns; irq=0.
- Write addr0=16'hA5A5 → LEDR=16'hA5A5 next edge. Read addr0 in the same cycle as a second write of 16'h0001 → returns 16'hA5A5.
- Write addr2=1234 → BUSY=1 for 17 cycles. HEX unchanged until edge 17, then HEX3..0 = 1,2,3,4 and OVF=0.
- Write addr2=9999, then addr2=12345 three cycles later → 9999 never appears. After 17 cycles from the second write, all digits "-" and OVF=1.
- DEB_CYCLES=4: SW toggles 16'h0000↔16'h0003 every 2 cycles then holds 16'h0003 → SW register stays 0 while toggling. It becomes 16'h0003 exactly 6 cycles after the hold starts; PEND=1.
- GPIO_IRQ_EN, IE=1: debounced SW change → irq=1 next cycle. W1C write of 4'b0100 to addr3 → irq=0. A clear in the same cycle as a new change → PEND stays 1.
